// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor baud generator: oversampled RX tick and 1x TX bit tick from one clock.
// Divisor is runtime-loadable; the RX phase can be restarted on a start-bit edge.

module uart_baud_gen_frac_chan #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  cur_int,
  input  logic [DIV_FRAC_W-1:0] cur_frac,
  output logic                  period_end
);

  localparam int CW = DIV_INT_W + 1;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         per;
  logic [DIV_FRAC_W-1:0] acc;
  logic                  extra;
  logic [DIV_FRAC_W:0]   sum;

  // Period length is cur_int plus the carry left by the previous period's phase step.
  assign per        = {1'b0, cur_int} + CW'(extra);
  assign sum        = {1'b0, acc} + {1'b0, cur_frac};
  assign period_end = run && !restart && (cnt + CW'(1) == per);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
    end else if (!run || restart) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
    end else if (period_end) begin
      cnt   <= '0;
      acc   <= sum[DIV_FRAC_W-1:0];
      extra <= sum[DIV_FRAC_W];
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

module uart_baud_gen_frac #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DEF_BAUD   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  rx_resync,
  output logic                  rx_tick,
  output logic                  tx_tick,
  output logic [DIV_INT_W-1:0]  cur_int,
  output logic [DIV_FRAC_W-1:0] cur_frac,
  output logic                  div_err
);

  localparam longint unsigned Q_RST =
    (longint'(CLK_FREQ) << DIV_FRAC_W) / (longint'(DEF_BAUD) * longint'(OVERSAMPLE));
  localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(Q_RST >> DIV_FRAC_W);
  localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(Q_RST);
  localparam int SUB_W = $clog2(OVERSAMPLE);

  // div_load and rx_resync are single-cycle strobes sampled on the clock edge; there is
  // no back-pressure. All outputs are single-cycle registered pulses except cur_int/cur_frac.
  logic             load_ok;
  logic             rx_restart;
  logic             rx_end;
  logic             tx_end;
  logic [SUB_W-1:0] sub;

  assign load_ok    = div_load && (div_int >= DIV_INT_W'(2));
  assign rx_restart = load_ok || rx_resync;

  uart_baud_gen_frac_chan #(
    .DIV_INT_W (DIV_INT_W),
    .DIV_FRAC_W(DIV_FRAC_W)
  ) u_rx_chan (
    .clk       (clk),
    .rst       (rst),
    .run       (en),
    .restart   (rx_restart),
    .cur_int   (cur_int),
    .cur_frac  (cur_frac),
    .period_end(rx_end)
  );

  uart_baud_gen_frac_chan #(
    .DIV_INT_W (DIV_INT_W),
    .DIV_FRAC_W(DIV_FRAC_W)
  ) u_tx_chan (
    .clk       (clk),
    .rst       (rst),
    .run       (en),
    .restart   (load_ok),
    .cur_int   (cur_int),
    .cur_frac  (cur_frac),
    .period_end(tx_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_int  <= RST_INT;
      cur_frac <= RST_FRAC;
      div_err  <= 1'b0;
      rx_tick  <= 1'b0;
    end else begin
      if (load_ok) begin
        cur_int  <= div_int;
        cur_frac <= div_frac;
      end
      div_err <= div_load && !load_ok;
      rx_tick <= rx_end;
    end
  end

  // A bit lasts OVERSAMPLE TX periods; the tick marks the period that wraps the sub-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub     <= '0;
      tx_tick <= 1'b0;
    end else if (!en || load_ok) begin
      sub     <= '0;
      tx_tick <= 1'b0;
    end else if (tx_end) begin
      sub     <= sub + SUB_W'(1);
      tx_tick <= (sub == SUB_W'(OVERSAMPLE - 1));
    end else begin
      tx_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: expected tick edge numbers are queued by the stimulus
// and a negedge monitor pops and compares them as ticks appear.

module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        div_load = 1'b0;
  logic        rx_resync = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        rx_tick;
  logic        tx_tick;
  logic        div_err;
  logic [15:0] cur_int;
  logic [3:0]  cur_frac;

  logic [31:0] cyc = '0;
  logic [31:0] exp_rx_q[$];
  logic [31:0] exp_tx_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  uart_baud_gen_frac dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .rx_resync(rx_resync),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick),
    .cur_int  (cur_int),
    .cur_frac (cur_frac),
    .div_err  (div_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edges from restart to the end of the n-th period for divisor ip + fp/16:
  // every period is ip long, and the fractional residue adds floor((n-1)*fp/16) extra edges.
  function automatic logic [31:0] cum(input int n, input int ip, input int fp);
    return 32'(n * ip + ((n - 1) * fp) / 16);
  endfunction

  task automatic push_rx(input logic [31:0] base, input int ip, input int fp,
                         input logic [31:0] hi);
    for (int n = 1; base + cum(n, ip, fp) <= hi; n++)
      exp_rx_q.push_back(base + cum(n, ip, fp));
  endtask

  task automatic push_tx(input logic [31:0] base, input int ip, input int fp,
                         input logic [31:0] hi);
    for (int m = 1; base + cum(16 * m, ip, fp) <= hi; m++)
      exp_tx_q.push_back(base + cum(16 * m, ip, fp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [31:0] e);
    while (cyc < e) step();
  endtask

  task automatic pulse_load(input logic [15:0] i, input logic [3:0] f);
    div_int  = i;
    div_frac = f;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    check({name, "_rx_q_left"}, 32'(exp_rx_q.size()), 32'd0);
    check({name, "_tx_q_left"}, 32'(exp_tx_q.size()), 32'd0);
    exp_rx_q.delete();
    exp_tx_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rx_tick) begin
      if (exp_rx_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_tick_unexpected: tick at cycle %0d, none required", cyc);
      end else begin
        e = exp_rx_q.pop_front();
        check("rx_tick_cycle", cyc, e);
      end
    end else if (exp_rx_q.size() != 0 && exp_rx_q[0] < cyc) begin
      e = exp_rx_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL rx_tick_missed: no tick by cycle %0d, required at %0d", cyc, e);
    end
    if (tx_tick) begin
      if (exp_tx_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tx_tick_unexpected: tick at cycle %0d, none required", cyc);
      end else begin
        e = exp_tx_q.pop_front();
        check("tx_tick_cycle", cyc, e);
      end
    end else if (exp_tx_q.size() != 0 && exp_tx_q[0] < cyc) begin
      e = exp_tx_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL tx_tick_missed: no tick by cycle %0d, required at %0d", cyc, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] base;
    logic [31:0] t;
    int          n;

    step();
    step();
    step();
    @(negedge clk);
    check("rst_rx_tick", 32'(rx_tick), 32'd0);
    check("rst_tx_tick", 32'(tx_tick), 32'd0);
    check("rst_div_err", 32'(div_err), 32'd0);
    check("rst_cur_int", 32'(cur_int), 32'd27);
    check("rst_cur_frac", 32'(cur_frac), 32'd2);

    // Case 1: defaults 27 + 2/16, start from reset.
    step();
    rst  = 1'b0;
    en   = 1'b1;
    base = cyc;
    push_rx(base, 27, 2, base + 900);
    push_tx(base, 27, 2, base + 900);
    run_to(base + 900);
    drain("c1");

    // Case 2: load 10.0 mid-period.
    pulse_load(16'd10, 4'd0);
    base = cyc;
    check("c2_cur_int", 32'(cur_int), 32'd10);
    check("c2_cur_frac", 32'(cur_frac), 32'd0);
    push_rx(base, 10, 0, base + 400);
    push_tx(base, 10, 0, base + 400);
    run_to(base + 400);
    drain("c2");

    // Case 3 and 4: back to 27.125, rejected load, then RX resync 5 cycles after a tick.
    pulse_load(16'd27, 4'd2);
    base = cyc;
    n = 1;
    while (cum(n, 27, 2) <= 32'd500) n++;
    t = base + cum(n, 27, 2);
    push_rx(base, 27, 2, t);
    push_tx(base, 27, 2, t + 505);
    run_to(base + 200);
    pulse_load(16'd1, 4'd5);
    check("c3_div_err_pulse", 32'(div_err), 32'd1);
    step();
    check("c3_div_err_clear", 32'(div_err), 32'd0);
    check("c3_cur_int_kept", 32'(cur_int), 32'd27);
    check("c3_cur_frac_kept", 32'(cur_frac), 32'd2);
    run_to(t + 4);
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    base = cyc;
    push_rx(base, 27, 2, base + 500);
    run_to(base + 500);
    drain("c4");

    // Case 5: en low for 100 cycles (resync while low is ignored).
    en = 1'b0;
    base = cyc;
    run_to(base + 50);
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    run_to(base + 100);
    check("c5_rx_quiet", 32'(rx_tick), 32'd0);
    check("c5_tx_quiet", 32'(tx_tick), 32'd0);
    en   = 1'b1;
    base = cyc;
    push_rx(base, 27, 2, base + 900);
    push_tx(base, 27, 2, base + 900);
    run_to(base + 900);
    drain("c5");

    // Case 6: reset mid-operation with a non-default divisor active.
    pulse_load(16'd10, 4'd0);
    base = cyc;
    push_rx(base, 10, 0, base + 15);
    run_to(base + 15);
    rst = 1'b1;
    #1;
    check("c6_rst_rx_tick", 32'(rx_tick), 32'd0);
    check("c6_rst_tx_tick", 32'(tx_tick), 32'd0);
    check("c6_rst_div_err", 32'(div_err), 32'd0);
    check("c6_rst_cur_int", 32'(cur_int), 32'd27);
    check("c6_rst_cur_frac", 32'(cur_frac), 32'd2);
    step();
    step();
    step();
    rst  = 1'b0;
    base = cyc;
    push_rx(base, 27, 2, base + 900);
    push_tx(base, 27, 2, base + 900);
    run_to(base + 900);
    drain("c6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
